// File: rtl/teatris_controle_mapas_if.sv
// Purpose : ROM and board-memory row link of the map loader.
//   master (loader) : drives endereco_rom, linha_valida, linha_indice, linha_dados;
//                     receives padrao_rom, linha_pronta.
//   slave  (ROM + board memory) : the mirror view.
interface teatris_controle_mapas_if #(
    parameter int unsigned NUM_LINHAS    = 8,
    parameter int unsigned LARGURA_LINHA = 8
);
    localparam int unsigned LARG_IDX     = 4;
    localparam int unsigned LARG_BUF     = NUM_LINHAS * LARGURA_LINHA;
    localparam int unsigned LARG_LIN_IDX = $clog2(NUM_LINHAS);

    logic [LARG_IDX-1:0]      endereco_rom;
    logic [LARG_BUF-1:0]      padrao_rom;
    logic                     linha_valida;
    logic                     linha_pronta;
    logic [LARG_LIN_IDX-1:0]  linha_indice;
    logic [LARGURA_LINHA-1:0] linha_dados;

    modport master (
        output endereco_rom,
        input  padrao_rom,
        output linha_valida,
        input  linha_pronta,
        output linha_indice,
        output linha_dados
    );

    modport slave (
        input  endereco_rom,
        output padrao_rom,
        input  linha_valida,
        output linha_pronta,
        input  linha_indice,
        input  linha_dados
    );
endinterface

// File: rtl/teatris_controle_mapas.sv
// Purpose : map loader. Addresses the 16-entry pattern ROM (1-cycle registered
//           read), captures the 8x8 pattern and streams it row by row (row 0 =
//           bits [63:56]) over a valid/ready link. Tracks the map index and a
//           saturating level count.
// Ports   : clock, reset (async, active-high)
//           iniciar, reiniciar_nivel  - requests, honoured only while idle
//           ocupado, concluido, nivel - status for the game controller
//           bus (master)              - ROM address/data and row handshake
// Option  : MAPA_ALEATORIO_EN - pick the next map from an 8-bit LFSR with no
//           immediate repeat instead of the sequential order 0..15.
module teatris_controle_mapas #(
    parameter int unsigned NUM_LINHAS    = 8,
    parameter int unsigned LARGURA_LINHA = 8,
    parameter int unsigned NIVEL_MAX     = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      reiniciar_nivel,
    output logic                      ocupado,
    output logic                      concluido,
    output logic [3:0]                nivel,
    teatris_controle_mapas_if.master  bus
);
    localparam int unsigned LARG_IDX     = 4;
    localparam int unsigned LARG_NIVEL   = 4;
    localparam int unsigned LARG_BUF     = NUM_LINHAS * LARGURA_LINHA;
    localparam int unsigned LARG_LIN_IDX = $clog2(NUM_LINHAS);
    localparam logic [LARG_LIN_IDX-1:0] ULTIMA_LINHA = LARG_LIN_IDX'(NUM_LINHAS - 1);
    localparam logic [LARG_NIVEL-1:0]   NIVEL_SAT    = LARG_NIVEL'(NIVEL_MAX);

    typedef enum logic [2:0] {
        OCIOSO,
        ENDERECA,
        AGUARDA,
        CARREGA,
        FIM
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [LARG_IDX-1:0]     indice_q, indice_d;
    logic [LARG_NIVEL-1:0]   nivel_q, nivel_d;
    logic [LARG_BUF-1:0]     buffer_q, buffer_d;
    logic [LARG_LIN_IDX-1:0] linha_q, linha_d;
    logic                    valida_q, valida_d;
    logic                    ocupado_q, ocupado_d;
    logic                    concluido_q, concluido_d;

`ifdef MAPA_ALEATORIO_EN
    logic [7:0]          lfsr_q, lfsr_d;
    logic [LARG_IDX-1:0] sorteio;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        nivel_d  = nivel_q;
        buffer_d = buffer_q;
        linha_d  = linha_q;
`ifdef MAPA_ALEATORIO_EN
        // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        sorteio = lfsr_q[3:0];
        if (sorteio == indice_q) begin
            sorteio = LARG_IDX'(sorteio + 4'd1);
        end
`endif

        case (estado_q)
            OCIOSO: begin
                // Clear is evaluated first so a simultaneous start loads map 0.
                if (reiniciar_nivel) begin
                    nivel_d = '0;
`ifndef MAPA_ALEATORIO_EN
                    indice_d = '0;
`endif
                end
                if (iniciar) begin
                    estado_d = ENDERECA;
`ifdef MAPA_ALEATORIO_EN
                    indice_d = sorteio;
`endif
                end
            end
            ENDERECA: estado_d = AGUARDA;
            AGUARDA: begin
                buffer_d = bus.padrao_rom;
                linha_d  = '0;
                estado_d = CARREGA;
            end
            CARREGA: begin
                // Buffer shifts up one row per transfer; its top byte is the current row.
                if (valida_q && bus.linha_pronta) begin
                    buffer_d = {buffer_q[LARG_BUF-LARGURA_LINHA-1:0], {LARGURA_LINHA{1'b0}}};
                    linha_d  = LARG_LIN_IDX'(linha_q + 1'b1);
                    if (linha_q == ULTIMA_LINHA) begin
                        estado_d = FIM;
                    end
                end
            end
            FIM: begin
                if (nivel_q < NIVEL_SAT) begin
                    nivel_d = LARG_NIVEL'(nivel_q + 1'b1);
                end
`ifndef MAPA_ALEATORIO_EN
                indice_d = LARG_IDX'(indice_q + 1'b1);
`endif
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        valida_d    = (estado_d == CARREGA);
        ocupado_d   = (estado_d != OCIOSO);
        concluido_d = (estado_d == FIM);
    end

    // State and output registers; reset aborts a load in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            indice_q    <= '0;
            nivel_q     <= '0;
            buffer_q    <= '0;
            linha_q     <= '0;
            valida_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
`ifdef MAPA_ALEATORIO_EN
            lfsr_q      <= 8'h01;
`endif
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            nivel_q     <= nivel_d;
            buffer_q    <= buffer_d;
            linha_q     <= linha_d;
            valida_q    <= valida_d;
            ocupado_q   <= ocupado_d;
            concluido_q <= concluido_d;
`ifdef MAPA_ALEATORIO_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign bus.endereco_rom = indice_q;
    assign bus.linha_valida = valida_q;
    assign bus.linha_indice = linha_q;
    assign bus.linha_dados  = buffer_q[LARG_BUF-1 -: LARGURA_LINHA];
    assign ocupado          = ocupado_q;
    assign concluido        = concluido_q;
    assign nivel            = nivel_q;
endmodule

// File: tb/tb_teatris_controle_mapas.sv
// Bench for teatris_controle_mapas: behavioural ROM, randomized map contents,
// randomized ready stalls and stray requests, expectations from a small model.
module tb_teatris_controle_mapas;
    logic clock;
    logic reset;
    logic iniciar;
    logic reiniciar_nivel;
    logic ocupado;
    logic concluido;
    logic [3:0] nivel;

    teatris_controle_mapas_if bus ();

    teatris_controle_mapas dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .reiniciar_nivel (reiniciar_nivel),
        .ocupado         (ocupado),
        .concluido       (concluido),
        .nivel           (nivel),
        .bus             (bus)
    );

    logic [63:0] rom_mem [16];
    int n_cmp = 0;
    int n_err = 0;
    int exp_idx;    // next map to load (sequential) / last loaded map (random build)
    int exp_nivel;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read pattern ROM
    always @(posedge clock) bus.padrao_rom <= rom_mem[bus.endereco_rom];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_endereco"}, bus.endereco_rom, 0);
        check({tag, "_valida"}, bus.linha_valida, 0);
        check({tag, "_indice"}, bus.linha_indice, 0);
        check({tag, "_dados"}, bus.linha_dados, 0);
        check({tag, "_ocupado"}, ocupado, 0);
        check({tag, "_concluido"}, concluido, 0);
        check({tag, "_nivel"}, nivel, 0);
    endtask

    // One load request, checked cycle by cycle. stall_row/stall_n: fixed stall;
    // rnd: random stalls; poke: stray requests while streaming; clr: clear with
    // the start; abort_row: assert reset when that row is first presented.
    task automatic do_load(input int stall_row, input int stall_n, input bit rnd,
                           input bit poke, input bit clr, input int abort_row);
        logic [63:0] pat;
        int e;
        int poke_row;
        poke_row = $urandom_range(0, 6);
        @(negedge clock);
        iniciar = 1'b1;
        reiniciar_nivel = clr;
        if (clr) begin
            exp_nivel = 0;
`ifndef MAPA_ALEATORIO_EN
            exp_idx = 0;
`endif
        end
        @(negedge clock);
        iniciar = 1'b0;
        reiniciar_nivel = 1'b0;
        // first busy cycle: ROM being addressed
`ifdef MAPA_ALEATORIO_EN
        check("sem_repeticao", (int'(bus.endereco_rom) == exp_idx) ? 1 : 0, 0);
        e = int'(bus.endereco_rom);
`else
        check("endereco", bus.endereco_rom, exp_idx);
        e = exp_idx;
`endif
        check("ocupado_ini", ocupado, 1);
        check("valida_end", bus.linha_valida, 0);
        @(negedge clock);
        check("valida_agu", bus.linha_valida, 0);
        check("endereco_est", bus.endereco_rom, e);
        pat = rom_mem[e];
        @(negedge clock);
        for (int r = 0; r < 8; r++) begin
            int n_wait;
            if (r == abort_row) begin
                bus.linha_pronta = 1'b0;
                check("abort_valida", bus.linha_valida, 1);
                reset = 1'b1;
                #1;
                check_zero("abort");
                @(negedge clock);
                check_zero("abort_hold");
                reset = 1'b0;
                exp_idx = 0;
                exp_nivel = 0;
                return;
            end
            n_wait = (r == stall_row) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
            for (int w = 0; w <= n_wait; w++) begin
                bus.linha_pronta = (w == n_wait);
                iniciar = poke && (r == poke_row) && (w == n_wait);
                reiniciar_nivel = iniciar;
                check("valida", bus.linha_valida, 1);
                check("linha_indice", bus.linha_indice, r);
                check("linha_dados", bus.linha_dados, pat[63-8*r -: 8]);
                check("concluido_cedo", concluido, 0);
                check("ocupado_linha", ocupado, 1);
                @(negedge clock);
            end
        end
        bus.linha_pronta = 1'b0;
        iniciar = 1'b0;
        reiniciar_nivel = 1'b0;
        check("concluido", concluido, 1);
        check("valida_fim", bus.linha_valida, 0);
        check("ocupado_fim", ocupado, 1);
        check("nivel_fim", nivel, exp_nivel);
        exp_nivel = (exp_nivel < 15) ? exp_nivel + 1 : 15;
`ifdef MAPA_ALEATORIO_EN
        exp_idx = e;
`else
        exp_idx = (e + 1) % 16;
`endif
        @(negedge clock);
        check("concluido_pulso", concluido, 0);
        check("ocupado_ocioso", ocupado, 0);
        check("nivel", nivel, exp_nivel);
        check("endereco_prox", bus.endereco_rom, exp_idx);
        @(negedge clock);
        check("sem_fila", ocupado, 0);
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        reiniciar_nivel = 1'b0;
        bus.linha_pronta = 1'b0;
        rom_mem[0] = 64'h0103_2010_C0C0_080C;
        rom_mem[1] = 64'h0202_2040_0206_6060;
        for (int i = 2; i < 16; i++) rom_mem[i] = {$urandom, $urandom};
        exp_idx = 0;
        exp_nivel = 0;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_zero("pos_reset");

        do_load(-1, 0, 0, 0, 0, -1);               // map 0, ready tied high
        do_load(-1, 0, 0, 0, 0, -1);               // map 1
        do_load(3, 5, 0, 0, 0, -1);                // 5-cycle stall on row 3
        for (int k = 0; k < 14; k++)               // up to 17 loads: saturation and wrap
            do_load(-1, 0, 1, 0, 0, -1);
        do_load(-1, 0, 1, 1, 0, -1);               // stray requests while busy

        // clear while idle
        @(negedge clock);
        reiniciar_nivel = 1'b1;
        @(negedge clock);
        reiniciar_nivel = 1'b0;
        exp_nivel = 0;
`ifndef MAPA_ALEATORIO_EN
        exp_idx = 0;
`endif
        check("nivel_limpo", nivel, 0);
        check("endereco_limpo", bus.endereco_rom, exp_idx);
        check("ocupado_limpo", ocupado, 0);

        do_load(-1, 0, 1, 0, 0, -1);
        do_load(-1, 0, 1, 0, 1, -1);               // clear and start together
        do_load(-1, 0, 0, 0, 0, 4);                // reset during row 4
        repeat (3) begin
            @(negedge clock);
            check("sem_concluido", concluido, 0);
            check("ocioso_pos_abort", ocupado, 0);
        end
        do_load(-1, 0, 1, 0, 0, -1);               // map 0 again after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
